alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares one combinational integer ALU among NREQ requesters (e.g. main execute path, address-gen helper, debug/test port).
- Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle and drives the ALU.
- The result is captured in a single-entry output register, tagged with the requester id.
- Sits between the issuing units and the shared ALU datapath in the single-cycle core's execute area.

Parameters:
- NREQ, 2, number of requesters (2..8)
- W, 32, operand/result width
- IDW, 1, width of rsp_id; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_op  in  4*NREQ  ALU op code, slice i belongs to requester i
- req_op1  in  W*NREQ  signed operand 1, slice i
- req_op2  in  W*NREQ  signed operand 2, slice i
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  IDW  index of the requester that produced rsp_res
- rsp_res  out  W  ALU result
- rsp_zero  out  1  rsp_res == 0
- rsp_illegal  out  1  op code was outside the defined set

Behaviour:
- Op encoding (4 bits):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA; shifts use op2[4:0]
  - 1000 SLT (signed), 1001 SLTU (unsigned)
  - 1010..1111 are illegal: res=0, zero=1, illegal=1
- Reset (rst=1 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_zero=0, rsp_illegal=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
  - Any in-flight result is discarded.
  - req_ready is 0 during the reset cycle.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Grant:
  - When can_accept, the winner is the first i with req_valid[i], searching last+1, last+2, … modulo NREQ.
  - req_ready[winner]=1; all other bits 0. If no valid request or !can_accept, req_ready=0.
  - req_ready must not depend on req_op/op1/op2.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. At that clock edge:
  - the output register loads res/zero/illegal from the ALU computed on the winner's operands;
  - rsp_id=winner; rsp_valid=1; last=winner.
- Latency: a request accepted in cycle t appears with rsp_valid=1 in cycle t+1.
- Throughput: 1 result per cycle while rsp_ready=1 (pass-through pipelining).
- Result pop with no new grant: rsp_valid && rsp_ready and no grant -> rsp_valid=0 next cycle. Data fields hold their old values.
- Backpressure: rsp_valid && !rsp_ready -> no grants. Output fields and last are stable until popped.
- Simultaneous pop and grant in the same cycle -> the register is overwritten with the new result and rsp_valid stays 1.
- Requesters may hold or drop req_valid freely. The block keeps no per-requester state besides last.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Arithmetic: W-bit wrap-around on ADD/SUB, no overflow flag. SLT compares as signed; SLTU as unsigned. SRA sign-extends.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 10 op codes plus OP_W=4;
  - a function alu_eval(op, op1, op2) returning {illegal, res}.
- One sub-module, rr_arbiter (parameter N):
  - inputs: req[N], last index, enable;
  - outputs: one-hot grant[N], grant index, any.
- The top contains the operand mux, the ALU evaluation and the output register.

Test Plan:
- Reset then single request: req0 ADD op1=5, op2=-7 -> next cycle rsp_valid=1, rsp_id=0, rsp_res=-2 (0xFFFFFFFE), zero=0, illegal=0.
- Both requesters valid every cycle, rsp_ready=1: grants alternate 0,1,0,1 starting with 0. Results of SUB 3-3 (req0) and SLTU 1 vs 0xFFFFFFFF (req1) give zero=1 then res=1.
- Backpressure: hold rsp_ready=0 for 3 cycles with both valid -> req_ready=0, rsp fields frozen. Release -> the pop and the next grant (requester after last) happen in the same cycle, rsp_valid stays 1.
- Shifts and signed ops: SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL same -> 1; SLL 1 by op2=33 -> 2; SLT -5 vs 3 -> 1.
- Illegal op 1111 -> res=0, zero=1, illegal=1; the next legal op clears illegal.
- Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0. The first grant after reset goes to requester 0 even if 1 was granted last.

Source files
------------

// File: rtl/alu_pkg.sv
// Op codes and the shared integer ALU evaluation used by alu_share_arb.
// Operands arrive sign-extended to ALU_XLEN; the caller truncates the result to its width.
package alu_pkg;

    localparam int OP_W     = 4;
    localparam int ALU_XLEN = 64;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b1001;

    // Returns {illegal, res}. Sign-extension keeps unsigned ordering intact, so
    // SLTU can compare the extended values directly; SRL masks back to w bits.
    function automatic logic [ALU_XLEN:0] alu_eval(
        input logic [OP_W-1:0]     op,
        input logic [ALU_XLEN-1:0] a,
        input logic [ALU_XLEN-1:0] b,
        input int                  w
    );
        logic [ALU_XLEN-1:0] mask;
        logic [ALU_XLEN-1:0] res;
        logic                illegal;
        logic [4:0]          sh;
        mask    = {ALU_XLEN{1'b1}} >> (ALU_XLEN - w);
        sh      = b[4:0];
        res     = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << sh;
            OP_SRL:  res = (a & mask) >> sh;
            OP_SRA:  res = $signed(a) >>> sh;
            OP_SLT:  res = ALU_XLEN'($signed(a) < $signed(b));
            OP_SLTU: res = ALU_XLEN'(a < b);
            default: illegal = 1'b1;
        endcase
        return {illegal, res};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches last+1, last+2, ... modulo N and grants the first request.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] hi;
    logic [N-1:0] pick;

    // Requests above last take precedence; otherwise wrap to the lowest index.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        hi    = '0;
        for (int i = 0; i < N; i++) begin
            hi[i] = req[i] && (i > int'(last));
        end
        pick = (|hi) ? hi : req;
        for (int i = 0; i < N; i++) begin
            if (en && !any && pick[i]) begin
                grant[i] = 1'b1;
                idx      = IW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// One combinational ALU shared by NREQ valid/ready requesters through a round-robin
// arbiter; results land in a single-entry output register tagged with the requester id.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [W*NREQ-1:0]    req_op1,
    input  logic [W*NREQ-1:0]    req_op2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_res,
    output logic                 rsp_zero,
    output logic                 rsp_illegal
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_res_q, rsp_res_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic [IDW-1:0]  last_q, last_d;

    logic                can_accept;
    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_any;
    logic [OP_W-1:0]     sel_op;
    logic [W-1:0]        sel_a;
    logic [W-1:0]        sel_b;
    logic [ALU_XLEN-1:0] alu_res_full;
    logic                alu_illegal;
    logic [W-1:0]        alu_res;

    assign can_accept = !rsp_valid_q || rsp_ready;

    // Grant is gated off during reset so nothing is accepted in that cycle.
    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .en    (can_accept && !rst),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op = req_op[i*OP_W +: OP_W];
                sel_a  = req_op1[i*W +: W];
                sel_b  = req_op2[i*W +: W];
            end
        end
    end

    assign {alu_illegal, alu_res_full} =
        alu_eval(sel_op, ALU_XLEN'($signed(sel_a)), ALU_XLEN'($signed(sel_b)), W);
    assign alu_res = W'(alu_res_full);

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_res_d     = rsp_res_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        last_d        = last_q;
        if (gnt_any) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = gnt_idx;
            rsp_res_d     = alu_res;
            rsp_zero_d    = (alu_res == '0);
            rsp_illegal_d = alu_illegal;
            last_d        = gnt_idx;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_res_q     <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            last_q        <= IDW'(NREQ - 1);
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_res_q     <= rsp_res_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
            last_q        <= last_d;
        end
    end

    assign req_ready   = gnt;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_res     = rsp_res_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
